// File: rtl/pipe_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the pipeline sequencer.
package pipe_sequencer_pkg;

    localparam int         ADDR_W_DEF = 20;
    localparam logic [6:0] HLT_OP_DEF = 7'b1100001;
    localparam logic [6:0] NOP_OP     = 7'b0000000;

    typedef enum logic [2:0] {
        VEC_LO = 3'd0,
        VEC_HI = 3'd1,
        RUN    = 3'd2,
        FREEZE = 3'd3,
        HALT   = 3'd4
    } seq_state_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc_val);
        return pc_val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_sequencer_if.sv
// Pipeline-side signal bundle between the sequencer (master) and the datapath/memories (slave).
interface pipe_sequencer_if
    import pipe_sequencer_pkg::*;
    #(parameter int ADDR_W = ADDR_W_DEF) ();

    logic [6:0]        id_opcode;
    logic [2:0]        id_rs1;
    logic [2:0]        id_rs2;
    logic              ex_mem_read;
    logic [2:0]        ex_rdst;
    logic              ex_branch_taken;
    logic [31:0]       ex_branch_target;
    logic              mem_busy;
    logic [15:0]       imem_data;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       pc;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_write;
    logic              idex_flush;
    logic              halted;

    modport master (
        input  id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rdst,
               ex_branch_taken, ex_branch_target, mem_busy, imem_data,
        output imem_addr, pc, ifid_write, ifid_flush, idex_write, idex_flush, halted
    );

    modport slave (
        output id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rdst,
               ex_branch_taken, ex_branch_target, mem_busy, imem_data,
        input  imem_addr, pc, ifid_write, ifid_flush, idex_write, idex_flush, halted
    );

endinterface

// File: rtl/pipe_sequencer_hazard.sv
// Load-use hazard detect: decode reads a register the load in execute has not yet produced.
module pipe_sequencer_hazard
    import pipe_sequencer_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [2:0] ex_rdst,
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    output logic       hazard
);

    // Hazard compare
    always_comb begin
        hazard = ex_mem_read & ((ex_rdst == id_rs1) | (ex_rdst == id_rs2));
    end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: reset-vector fetch, pc register and stall/flush/halt control.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter logic [6:0] HLT_OP = HLT_OP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pipe_sequencer_if.master bus
);

    seq_state_t  state_r;
    seq_state_t  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        hazard_s;
    logic        hlt_s;

    pipe_sequencer_hazard u_hazard (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rdst     (bus.ex_rdst),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .hazard      (hazard_s)
    );

    assign hlt_s  = (bus.id_opcode == HLT_OP);
    assign bus.pc = pc_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= VEC_LO;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    // Next state and next pc; FREEZE without mem_busy behaves exactly like RUN
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        case (state_r)
            VEC_LO: begin
                state_nxt_s = VEC_HI;
                pc_nxt_s    = {pc_r[31:16], bus.imem_data};
            end
            VEC_HI: begin
                state_nxt_s = RUN;
                pc_nxt_s    = {bus.imem_data, pc_r[15:0]};
            end
            RUN, FREEZE: begin
                if (bus.mem_busy) begin
                    state_nxt_s = FREEZE;
                end else if (bus.ex_branch_taken) begin
                    state_nxt_s = RUN;
                    pc_nxt_s    = bus.ex_branch_target;
                end else if (hlt_s) begin
                    state_nxt_s = HALT;
                end else if (hazard_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = RUN;
                    pc_nxt_s    = pc_incr(pc_r);
                end
            end
            HALT: begin
                state_nxt_s = HALT;
            end
            default: begin
                state_nxt_s = VEC_LO;
            end
        endcase
    end

    // Pipeline register control and instruction address
    always_comb begin
        bus.imem_addr  = pc_r[ADDR_W-1:0];
        bus.ifid_write = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_write = 1'b0;
        bus.idex_flush = 1'b0;
        bus.halted     = 1'b0;
        case (state_r)
            VEC_LO: begin
                bus.imem_addr  = {ADDR_W{1'b0}};
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end
            VEC_HI: begin
                bus.imem_addr  = {{(ADDR_W-1){1'b0}}, 1'b1};
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end
            RUN, FREEZE: begin
                if (bus.mem_busy) begin
                    bus.ifid_write = 1'b0;
                end else if (bus.ex_branch_taken) begin
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end else if (hlt_s) begin
                    bus.idex_write = 1'b1;
                end else if (hazard_s) begin
                    bus.idex_flush = 1'b1;
                end else begin
                    bus.ifid_write = 1'b1;
                    bus.idex_write = 1'b1;
                end
            end
            HALT: begin
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
                bus.halted     = 1'b1;
            end
            default: begin
                bus.imem_addr  = {ADDR_W{1'b0}};
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Randomised self-checking bench for pipe_sequencer against a cycle-level behavioural model.
module tb_pipe_sequencer;
    import pipe_sequencer_pkg::*;

    localparam logic [6:0] HLT = 7'b1100001;
    localparam int PH_VLO  = 0;
    localparam int PH_VHI  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_HALT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] vec_lo = 16'h0000;
    logic [15:0] vec_hi = 16'h0000;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          flush_cnt = 0;
    int          m_phase = PH_VLO;
    logic [31:0] m_pc = 32'd0;

    always #5 clk = ~clk;

    pipe_sequencer_if #(.ADDR_W(20)) bus ();

    pipe_sequencer #(.ADDR_W(20), .HLT_OP(7'b1100001)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: two vector words, then an address-derived pattern
    assign bus.imem_data = (bus.imem_addr == 20'd0) ? vec_lo :
                           (bus.imem_addr == 20'd1) ? vec_hi :
                           (bus.imem_addr[15:0] ^ 16'hA5A5);

    task automatic idle();
        bus.id_opcode        = NOP_OP;
        bus.id_rs1           = 3'd1;
        bus.id_rs2           = 3'd2;
        bus.ex_mem_read      = 1'b0;
        bus.ex_rdst          = 3'd0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = 32'd0;
        bus.mem_busy         = 1'b0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model
    task automatic step(input string tag);
        logic [4:0]  e_ctrl;
        logic [4:0]  a_ctrl;
        logic [19:0] e_addr;
        logic [31:0] npc;
        int          nphase;
        logic        haz;
        @(negedge clk);
        haz    = bus.ex_mem_read && ((bus.ex_rdst == bus.id_rs1) || (bus.ex_rdst == bus.id_rs2));
        e_addr = m_pc[19:0];
        npc    = m_pc;
        nphase = m_phase;
        // e_ctrl = {ifid_write, ifid_flush, idex_write, idex_flush, halted}
        e_ctrl = 5'b00000;
        if (m_phase == PH_VLO) begin
            e_addr = 20'd0; e_ctrl = 5'b01010; npc = {m_pc[31:16], vec_lo}; nphase = PH_VHI;
        end else if (m_phase == PH_VHI) begin
            e_addr = 20'd1; e_ctrl = 5'b01010; npc = {vec_hi, m_pc[15:0]}; nphase = PH_RUN;
        end else if (m_phase == PH_HALT) begin
            e_ctrl = 5'b01011;
        end else if (bus.mem_busy) begin
            e_ctrl = 5'b00000;
        end else if (bus.ex_branch_taken) begin
            e_ctrl = 5'b01010; npc = bus.ex_branch_target;
        end else if (bus.id_opcode == HLT) begin
            e_ctrl = 5'b00100; nphase = PH_HALT;
        end else if (haz) begin
            e_ctrl = 5'b00010;
        end else begin
            e_ctrl = 5'b10100; npc = m_pc + 32'd1;
        end
        a_ctrl = {bus.ifid_write, bus.ifid_flush, bus.idex_write, bus.idex_flush, bus.halted};
        n_cmp++;
        if (bus.pc !== m_pc) begin
            n_bad++;
            $display("FAIL %s pc: got %h expected %h", tag, bus.pc, m_pc);
        end
        n_cmp++;
        if (bus.imem_addr !== e_addr) begin
            n_bad++;
            $display("FAIL %s imem_addr: got %h expected %h", tag, bus.imem_addr, e_addr);
        end
        n_cmp++;
        if (a_ctrl !== e_ctrl) begin
            n_bad++;
            $display("FAIL %s ctrl{ifw,ifl,idw,idl,hlt}: got %b expected %b", tag, a_ctrl, e_ctrl);
        end
        if (bus.idex_flush === 1'b1) flush_cnt++;
        @(posedge clk);
        #1;
        m_phase = nphase;
        m_pc    = npc;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp);
        n_cmp++;
        if (bus.pc !== exp) begin
            n_bad++;
            $display("FAIL %s: pc got %h expected %h", tag, bus.pc, exp);
        end
    endtask

    // Asserts reset off-edge and checks its asynchronous effect before any clock edge
    task automatic do_reset(input logic [15:0] lo, input logic [15:0] hi);
        vec_lo = lo;
        vec_hi = hi;
        reset  = 1'b1;
        #1;
        n_cmp++;
        if (bus.pc !== 32'd0 || bus.imem_addr !== 20'd0) begin
            n_bad++;
            $display("FAIL async_reset: pc %h addr %h expected 0/0", bus.pc, bus.imem_addr);
        end
        n_cmp++;
        if ({bus.ifid_write, bus.ifid_flush, bus.idex_write, bus.idex_flush, bus.halted} !== 5'b01010) begin
            n_bad++;
            $display("FAIL async_reset ctrl: got %b expected 01010",
                     {bus.ifid_write, bus.ifid_flush, bus.idex_write, bus.idex_flush, bus.halted});
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_phase = PH_VLO;
        m_pc    = 32'd0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        do_reset(16'h0010, 16'h0000);
    endtask

    task automatic test_vector();
        step("vec_lo");
        step("vec_hi");
        check_pc("vector_pc", 32'h0000_0010);
        for (int i = 0; i < 4; i++) step("run_inc");
        check_pc("run_inc_pc", 32'h0000_0014);
    endtask

    task automatic test_load_use();
        logic [31:0] p0;
        p0 = bus.pc;
        flush_cnt = 0;
        bus.ex_mem_read = 1'b1; bus.ex_rdst = 3'd3; bus.id_rs1 = 3'd5; bus.id_rs2 = 3'd3;
        step("load_use");
        check_pc("load_use_hold", p0);
        idle();
        for (int i = 0; i < 3; i++) step("after_load_use");
        check_pc("load_use_resume", p0 + 32'd3);
        n_cmp++;
        if (flush_cnt != 1) begin
            n_bad++;
            $display("FAIL load_use_bubbles: got %0d expected 1", flush_cnt);
        end
    endtask

    task automatic test_branch_hlt();
        do_reset(16'h0020, 16'h0000);
        idle();
        step("vec_lo"); step("vec_hi");
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h100; bus.id_opcode = HLT;
        step("branch_over_hlt");
        check_pc("branch_target", 32'h0000_0100);
        idle();
        step("post_branch"); step("post_branch");
        n_cmp++;
        if (bus.halted !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_hlt_halted: got %b expected 0", bus.halted);
        end
    endtask

    task automatic test_halt();
        do_reset(16'h0030, 16'h0000);
        idle();
        step("vec_lo"); step("vec_hi");
        bus.id_opcode = HLT;
        step("hlt_decode");
        for (int i = 0; i < 6; i++) begin
            bus.ex_branch_taken  = 1'b1;
            bus.ex_branch_target = $urandom;
            bus.mem_busy         = 1'($urandom_range(0, 1));
            bus.id_opcode        = 7'($urandom);
            step("halted");
        end
        check_pc("halt_pc", 32'h0000_0030);
        n_cmp++;
        if (bus.halted !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_flag: got %b expected 1", bus.halted);
        end
    endtask

    task automatic test_freeze_hazard();
        do_reset(16'h0040, 16'h0000);
        idle();
        step("vec_lo"); step("vec_hi");
        flush_cnt = 0;
        bus.mem_busy = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rdst = 3'd4; bus.id_rs1 = 3'd4;
        for (int i = 0; i < 3; i++) step("freeze");
        check_pc("freeze_pc", 32'h0000_0040);
        bus.mem_busy = 1'b0;
        step("freeze_then_bubble");
        idle();
        step("after_bubble");
        check_pc("freeze_resume_pc", 32'h0000_0041);
        n_cmp++;
        if (flush_cnt != 1) begin
            n_bad++;
            $display("FAIL freeze_bubbles: got %0d expected 1", flush_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset(16'hFFFF, 16'hFFFF);
        idle();
        step("vec_lo"); step("vec_hi");
        check_pc("wrap_start", 32'hFFFF_FFFF);
        step("wrap");
        check_pc("wrap_zero", 32'h0000_0000);
    endtask

    task automatic test_reset_abort();
        do_reset(16'h0050, 16'h0000);
        idle();
        step("vec_lo"); step("vec_hi");
        bus.mem_busy = 1'b1;
        step("freeze_before_reset");
        do_reset(16'h0060, 16'h0000);
        idle();
        step("vec_lo_before_reset");
        do_reset(16'h0070, 16'h0000);
        step("vec_lo"); step("vec_hi");
        check_pc("after_vec_abort", 32'h0000_0070);
        bus.id_opcode = HLT;
        step("hlt_before_reset");
        idle();
        step("halted_before_reset");
        do_reset(16'h0080, 16'h0001);
        step("vec_lo"); step("vec_hi");
        check_pc("after_halt_reset", 32'h0001_0080);
    endtask

    task automatic test_random();
        int halt_cycles;
        halt_cycles = 0;
        do_reset(16'($urandom), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0 || halt_cycles > 4) begin
                do_reset(16'($urandom), 16'($urandom));
                halt_cycles = 0;
            end
            bus.id_opcode        = ($urandom_range(0, 15) == 0) ? HLT : 7'($urandom);
            bus.id_rs1           = 3'($urandom);
            bus.id_rs2           = 3'($urandom);
            bus.ex_mem_read      = 1'($urandom_range(0, 1));
            bus.ex_rdst          = 3'($urandom);
            bus.ex_branch_taken  = ($urandom_range(0, 7) == 0);
            bus.ex_branch_target = $urandom;
            bus.mem_busy         = ($urandom_range(0, 3) == 0);
            step("random");
            if (m_phase == PH_HALT) halt_cycles++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_vector();
        test_load_use();
        test_branch_hlt();
        test_halt();
        test_freeze_hazard();
        test_wrap();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: PIPE_SEQUENCER

Interface
REQ-001 Parameter ADDR_W, default 20, instruction-memory word-address width.
REQ-002 Parameter HLT_OP, default 7'b1100001, opcode of HLT.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 id_opcode  in  7  opcode of the instruction in decode.
REQ-006 id_rs1, id_rs2  in  3 each  source register fields of the decode instruction.
REQ-007 ex_mem_read  in  1  instruction in execute is a load.
REQ-008 ex_rdst  in  3  destination register of the execute instruction.
REQ-009 ex_branch_taken  in  1  execute resolved a taken branch or jump.
REQ-010 ex_branch_target  in  32  target PC of the taken branch.
REQ-011 mem_busy  in  1  data memory requests a pipeline freeze.
REQ-012 imem_data  in  16  instruction-memory read data, combinational from imem_addr.
REQ-013 imem_addr  out  ADDR_W  instruction-memory word address.
REQ-014 pc  out  32  registered program counter.
REQ-015 ifid_write  out  1  IF/ID register load enable.
REQ-016 ifid_flush  out  1  IF/ID register clear to NOP.
REQ-017 idex_write  out  1  ID/EX register load enable.
REQ-018 idex_flush  out  1  ID/EX register insert bubble.
REQ-019 halted  out  1  processor is halted.

Function
REQ-020 FSM states: VEC_LO, VEC_HI, RUN, FREEZE, HALT.
REQ-021 VEC_LO: imem_addr=0; pc[15:0]<=imem_data; next VEC_HI; ifid_flush=idex_flush=1; ifid_write=idex_write=0.
REQ-022 VEC_HI: imem_addr=1; pc[31:16]<=imem_data; next RUN; flushes and enables as in VEC_LO.
REQ-023 RUN/FREEZE/HALT: imem_addr=pc[ADDR_W-1:0], upper pc bits ignored.
REQ-024 RUN event priority: mem_busy > ex_branch_taken > HLT in decode > load-use hazard > normal.
REQ-025 mem_busy=1 in RUN or FREEZE: pc, IF/ID and ID/EX hold (both writes 0, no flushes); state FREEZE.
REQ-026 FREEZE with mem_busy=0: return to RUN; that cycle is evaluated as RUN.
REQ-027 Branch: pc<=ex_branch_target; ifid_flush=idex_flush=1; a concurrent HLT or hazard is discarded.
REQ-028 HLT (id_opcode==HLT_OP): pc holds; ifid_write=0; idex_write=1 (HLT proceeds); next HALT.
REQ-029 Load-use hazard = ex_mem_read & (ex_rdst==id_rs1 | ex_rdst==id_rs2): pc holds; ifid_write=0; idex_flush=1, exactly one bubble per hazard.
REQ-030 Normal: pc<=pc+1, 32-bit wrap 32'hFFFFFFFF->0; ifid_write=idex_write=1; no flushes.
REQ-031 HALT: pc holds; ifid_write=0; ifid_flush=1; idex_flush=1; halted=1; exit only via reset; all inputs ignored.
REQ-032 halted=1 only in HALT; outputs other than pc are combinational from state and inputs.

Reset
REQ-033 reset=1 asynchronously forces state=VEC_LO, pc=0, with outputs imem_addr=0, ifid_flush=idex_flush=1, ifid_write=idex_write=0, halted=0.
REQ-034 reset asserted mid-freeze, mid-vector-load or in HALT aborts the operation; the vector fetch restarts from VEC_LO after deassertion.

Structure
REQ-035 The shared package/include holds the opcode constants (HLT, NOP), the state encoding and ADDR_W default.
REQ-036 One combinational sub-module HAZARD_DETECT computes the load-use hazard; FSM and pc register live in PIPE_SEQUENCER.

Verification
REQ-037 Reset, imem word0=16'h0010, word1=16'h0000 -> pc=32'h00000010 after two cycles, state RUN, then pc increments by 1 per cycle.
REQ-038 RUN, ex_mem_read=1, ex_rdst=3, id_rs2=3 for one cycle -> pc held one cycle, idex_flush=1 once, then normal increment.
REQ-039 pc=0x20, ex_branch_taken=1, target=0x100, id_opcode=HLT same cycle -> pc=0x100, both flushes=1, halted stays 0.
REQ-040 id_opcode=HLT at pc=0x30 -> next cycle halted=1, pc stays 0x30 indefinitely; branch input ignored.
REQ-041 mem_busy=1 for 3 cycles with concurrent hazard -> pc/IF/ID/ID/EX frozen 3 cycles, then the hazard bubble is inserted.
REQ-042 pc=32'hFFFFFFFF normal cycle -> pc=0; reset asserted during FREEZE -> pc=0, state VEC_LO immediately.
